// File: rtl/btb_upd_arb_if.sv
// BTB update arbiter bus: two requesters (mispredict, commit), kill, and the BTB write port.
// slave = arbiter side, master = backend/BTB side.
interface btb_upd_arb_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             mp_valid;
    logic             mp_ready;
    logic [31:0]      mp_pc;
    logic [31:0]      mp_target;
    logic             cm_valid;
    logic             cm_ready;
    logic [31:0]      cm_pc;
    logic [31:0]      cm_target;
    logic             kill;
    logic             btb_wr_stall;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] coalesce_cnt;

    modport slave (
        input  mp_valid, mp_pc, mp_target,
        input  cm_valid, cm_pc, cm_target,
        input  kill, btb_wr_stall,
        output mp_ready, cm_ready,
        output upd_valid, upd_pc, upd_target,
        output occupancy, coalesce_cnt
    );

    modport master (
        output mp_valid, mp_pc, mp_target,
        output cm_valid, cm_pc, cm_target,
        output kill, btb_wr_stall,
        input  mp_ready, cm_ready,
        input  upd_valid, upd_pc, upd_target,
        input  occupancy, coalesce_cnt
    );
endinterface

// File: rtl/btb_upd_arb.sv
// BTB update arbiter / write queue: merges same-PC taken-branch updates from the
// mispredict and commit paths and drains them to the BTB one per cycle, in order.
module btb_upd_arb #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    btb_upd_arb_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned PC_W  = 32;

    logic [PC_W-1:0]  r_pc  [DEPTH];
    logic [PC_W-1:0]  r_tgt [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pop;
    logic             w_full;
    logic             w_mp_hit;
    logic             w_cm_hit;
    logic [PTR_W-1:0] w_mp_idx;
    logic [PTR_W-1:0] w_cm_idx;
    logic             w_mp_ready;
    logic             w_cm_ready;
    logic             w_acc_mp;
    logic             w_acc_cm;
    logic             w_acc;
    logic             w_hit;
    logic [PTR_W-1:0] w_idx;
    logic [PC_W-1:0]  w_pc;
    logic [PC_W-1:0]  w_tgt;
    logic             w_alloc;
    logic             w_merge;
    logic [OCC_W-1:0] w_occ_nxt;

    assign w_pop  = (r_occ != '0) && !bus.btb_wr_stall && !bus.kill;
    assign w_full = (r_occ == OCC_W'(DEPTH));

    // Full-PC CAM lookup; the head leaving this cycle cannot absorb a merge.
    always_comb begin
        w_mp_hit = 1'b0;
        w_mp_idx = '0;
        w_cm_hit = 1'b0;
        w_cm_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_vld[i] && !(w_pop && (r_head == PTR_W'(i)))) begin
                if (r_pc[i] == bus.mp_pc) begin
                    w_mp_hit = 1'b1;
                    w_mp_idx = PTR_W'(i);
                end
                if (r_pc[i] == bus.cm_pc) begin
                    w_cm_hit = 1'b1;
                    w_cm_idx = PTR_W'(i);
                end
            end
        end
    end

    // Ready never looks at the requester's own valid; cm yields whenever mp asks.
    assign w_mp_ready = !bus.kill && (!w_full || w_pop || w_mp_hit);
    assign w_cm_ready = !bus.kill && !bus.mp_valid && (!w_full || w_pop || w_cm_hit);

    assign w_acc_mp = bus.mp_valid && w_mp_ready;
    assign w_acc_cm = bus.cm_valid && w_cm_ready;
    assign w_acc    = w_acc_mp || w_acc_cm;

    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_pc  = '0;
        w_tgt = '0;
        if (w_acc_mp) begin
            w_hit = w_mp_hit;
            w_idx = w_mp_idx;
            w_pc  = bus.mp_pc;
            w_tgt = bus.mp_target;
        end else if (w_acc_cm) begin
            w_hit = w_cm_hit;
            w_idx = w_cm_idx;
            w_pc  = bus.cm_pc;
            w_tgt = bus.cm_target;
        end
    end

    assign w_alloc   = w_acc && !w_hit;
    assign w_merge   = w_acc && w_hit;
    assign w_occ_nxt = r_occ + OCC_W'(w_alloc) - OCC_W'(w_pop);

    // Control state; on full+pop+alloc the tail slot equals the head slot, so the
    // allocate's valid set is ordered after the pop's clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_vld  <= '0;
            r_cnt  <= '0;
        end else if (bus.kill) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_vld  <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            if (w_alloc) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_merge && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_occ <= w_occ_nxt;
        end
    end

    // Payload storage needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !bus.kill) begin
            if (w_alloc) begin
                r_pc[r_tail]  <= w_pc;
                r_tgt[r_tail] <= w_tgt;
            end
            if (w_merge) begin
                r_tgt[w_idx] <= w_tgt;
            end
        end
    end

    assign bus.mp_ready     = w_mp_ready;
    assign bus.cm_ready     = w_cm_ready;
    assign bus.upd_valid    = w_pop;
    assign bus.upd_pc       = r_pc[r_head];
    assign bus.upd_target   = r_tgt[r_head];
    assign bus.occupancy    = r_occ;
    assign bus.coalesce_cnt = r_cnt;
endmodule

// File: tb/tb_btb_upd_arb.sv
// Directed bench for btb_upd_arb: reset, single update, priority, coalesce,
// backpressure, full+pop, back-to-back drain, kill and mid-run reset.
module tb_btb_upd_arb;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [15:0] exp_cnt;

    btb_upd_arb_if #(.DEPTH(4), .CNT_W(16)) bus ();

    btb_upd_arb #(.DEPTH(4), .CNT_W(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mp_valid     = 1'b0;
        bus.mp_pc        = '0;
        bus.mp_target    = '0;
        bus.cm_valid     = 1'b0;
        bus.cm_pc        = '0;
        bus.cm_target    = '0;
        bus.kill         = 1'b0;
        bus.btb_wr_stall = 1'b0;
    endtask

    task automatic push_mp(input logic [31:0] pc, input logic [31:0] tgt);
        bus.mp_valid  = 1'b1;
        bus.mp_pc     = pc;
        bus.mp_target = tgt;
        step();
        bus.mp_valid  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_vec++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL reset_upd_valid got=%0b exp=0", bus.upd_valid); end
        n_vec++; if (bus.mp_ready !== 1'b1) begin n_err++; $display("FAIL reset_mp_ready got=%0b exp=1", bus.mp_ready); end
        n_vec++; if (bus.cm_ready !== 1'b1) begin n_err++; $display("FAIL reset_cm_ready got=%0b exp=1", bus.cm_ready); end
        n_vec++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
        n_vec++; if (bus.coalesce_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", bus.coalesce_cnt); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_single();
        bus.mp_valid  = 1'b1;
        bus.mp_pc     = 32'h100;
        bus.mp_target = 32'h200;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got=%0b exp=1", bus.mp_ready); end
        n_vec++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got=%0b exp=0", bus.upd_valid); end
        step();
        bus.mp_valid = 1'b0;
        #1;
        n_vec++; if (bus.upd_valid !== 1'b1) begin n_err++; $display("FAIL single_upd_valid got=%0b exp=1", bus.upd_valid); end
        n_vec++; if (bus.upd_pc !== 32'h100) begin n_err++; $display("FAIL single_pc got=%h exp=100", bus.upd_pc); end
        n_vec++; if (bus.upd_target !== 32'h200) begin n_err++; $display("FAIL single_tgt got=%h exp=200", bus.upd_target); end
        n_vec++; if (bus.occupancy !== 3'd1) begin n_err++; $display("FAIL single_occ1 got=%0d exp=1", bus.occupancy); end
        step();
        n_vec++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL single_occ0 got=%0d exp=0", bus.occupancy); end
        n_vec++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got=%0b exp=0", bus.upd_valid); end
    endtask

    task automatic test_priority();
        bus.mp_valid  = 1'b1; bus.mp_pc = 32'h10; bus.mp_target = 32'h1000;
        bus.cm_valid  = 1'b1; bus.cm_pc = 32'h20; bus.cm_target = 32'h2000;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b1) begin n_err++; $display("FAIL prio_mp_ready got=%0b exp=1", bus.mp_ready); end
        n_vec++; if (bus.cm_ready !== 1'b0) begin n_err++; $display("FAIL prio_cm_blocked got=%0b exp=0", bus.cm_ready); end
        step();
        bus.mp_valid = 1'b0;
        #1;
        n_vec++; if (bus.cm_ready !== 1'b1) begin n_err++; $display("FAIL prio_cm_ready got=%0b exp=1", bus.cm_ready); end
        n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h10) begin n_err++; $display("FAIL prio_first got=%0b/%h exp=1/10", bus.upd_valid, bus.upd_pc); end
        step();
        bus.cm_valid = 1'b0;
        #1;
        n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h20 || bus.upd_target !== 32'h2000) begin n_err++; $display("FAIL prio_second got=%0b/%h/%h exp=1/20/2000", bus.upd_valid, bus.upd_pc, bus.upd_target); end
        step();
        n_vec++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL prio_occ got=%0d exp=0", bus.occupancy); end
    endtask

    task automatic test_coalesce();
        bus.btb_wr_stall = 1'b1;
        bus.cm_valid = 1'b1; bus.cm_pc = 32'h40; bus.cm_target = 32'h80;
        step();
        bus.cm_valid = 1'b0;
        bus.mp_valid = 1'b1; bus.mp_pc = 32'h40; bus.mp_target = 32'hC0;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b1) begin n_err++; $display("FAIL coal_ready got=%0b exp=1", bus.mp_ready); end
        step();
        bus.mp_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        #1;
        n_vec++; if (bus.occupancy !== 3'd1) begin n_err++; $display("FAIL coal_occ got=%0d exp=1", bus.occupancy); end
        n_vec++; if (bus.coalesce_cnt !== exp_cnt) begin n_err++; $display("FAIL coal_cnt got=%0d exp=%0d", bus.coalesce_cnt, exp_cnt); end
        n_vec++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL coal_stalled got=%0b exp=0", bus.upd_valid); end
        bus.btb_wr_stall = 1'b0;
        #1;
        n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h40 || bus.upd_target !== 32'hC0) begin n_err++; $display("FAIL coal_write got=%0b/%h/%h exp=1/40/c0", bus.upd_valid, bus.upd_pc, bus.upd_target); end
        step();
        n_vec++; if (bus.occupancy !== 3'd0 || bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL coal_single got=%0d/%0b exp=0/0", bus.occupancy, bus.upd_valid); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc  [4];
        logic [31:0] exp_tgt [4];
        exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_tgt = '{32'h1000, 32'h1004, 32'h9999, 32'h100C};
        bus.btb_wr_stall = 1'b1;
        push_mp(32'h0, 32'h1000);
        push_mp(32'h4, 32'h1004);
        push_mp(32'h8, 32'h1008);
        push_mp(32'hC, 32'h100C);
        #1;
        n_vec++; if (bus.occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ got=%0d exp=4", bus.occupancy); end
        bus.mp_pc = 32'h50; bus.mp_target = 32'h5000;
        bus.cm_pc = 32'h50;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b0) begin n_err++; $display("FAIL full_mp_block got=%0b exp=0", bus.mp_ready); end
        n_vec++; if (bus.cm_ready !== 1'b0) begin n_err++; $display("FAIL full_cm_block got=%0b exp=0", bus.cm_ready); end
        bus.mp_valid = 1'b1; bus.mp_pc = 32'h8; bus.mp_target = 32'h9999;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b1) begin n_err++; $display("FAIL full_match_ready got=%0b exp=1", bus.mp_ready); end
        step();
        bus.mp_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        #1;
        n_vec++; if (bus.coalesce_cnt !== exp_cnt || bus.occupancy !== 3'd4) begin n_err++; $display("FAIL full_merge got=%0d/%0d exp=%0d/4", bus.coalesce_cnt, bus.occupancy, exp_cnt); end
        bus.btb_wr_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_pc[k] || bus.upd_target !== exp_tgt[k]) begin n_err++; $display("FAIL full_drain%0d got=%0b/%h/%h exp=1/%h/%h", k, bus.upd_valid, bus.upd_pc, bus.upd_target, exp_pc[k], exp_tgt[k]); end
            step();
        end
        n_vec++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL full_empty got=%0d exp=0", bus.occupancy); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h104, 32'h108, 32'h10C, 32'h200};
        bus.btb_wr_stall = 1'b1;
        push_mp(32'h100, 32'h1);
        push_mp(32'h104, 32'h2);
        push_mp(32'h108, 32'h3);
        push_mp(32'h10C, 32'h4);
        bus.btb_wr_stall = 1'b0;
        bus.mp_valid = 1'b1; bus.mp_pc = 32'h200; bus.mp_target = 32'h300;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b1) begin n_err++; $display("FAIL fpop_ready got=%0b exp=1", bus.mp_ready); end
        n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h100) begin n_err++; $display("FAIL fpop_head got=%0b/%h exp=1/100", bus.upd_valid, bus.upd_pc); end
        step();
        bus.mp_valid = 1'b0;
        #1;
        n_vec++; if (bus.occupancy !== 3'd4) begin n_err++; $display("FAIL fpop_occ got=%0d exp=4", bus.occupancy); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_pc[k]) begin n_err++; $display("FAIL fpop_drain%0d got=%0b/%h exp=1/%h", k, bus.upd_valid, bus.upd_pc, exp_pc[k]); end
            step();
            #1;
        end
        n_vec++; if (bus.upd_target === 32'h300 && bus.upd_valid === 1'b1) begin n_err++; $display("FAIL fpop_extra got=%0b exp=0", bus.upd_valid); end
        n_vec++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL fpop_empty got=%0d exp=0", bus.occupancy); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            bus.mp_valid = 1'b1; bus.mp_pc = 32'h600 + 32'(4 * k); bus.mp_target = 32'h700 + 32'(k);
            #1;
            if (k > 0) begin
                n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h600 + 32'(4 * (k - 1)) || bus.occupancy !== 3'd1) begin n_err++; $display("FAIL b2b_%0d got=%0b/%h/%0d exp=1/%h/1", k, bus.upd_valid, bus.upd_pc, bus.occupancy, 32'h600 + 32'(4 * (k - 1))); end
            end
            step();
        end
        bus.mp_valid = 1'b0;
        #1;
        n_vec++; if (bus.upd_pc !== 32'h60C || bus.upd_target !== 32'h703) begin n_err++; $display("FAIL b2b_last got=%h/%h exp=60c/703", bus.upd_pc, bus.upd_target); end
        step();
        // Same PC as the head being popped must allocate, not merge into it.
        push_mp(32'h500, 32'h1);
        bus.mp_valid = 1'b1; bus.mp_pc = 32'h500; bus.mp_target = 32'h2;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b1 || bus.upd_target !== 32'h1) begin n_err++; $display("FAIL b2b_hdx_first got=%0b/%h exp=1/1", bus.mp_ready, bus.upd_target); end
        step();
        bus.mp_valid = 1'b0;
        #1;
        n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h500 || bus.upd_target !== 32'h2) begin n_err++; $display("FAIL b2b_hdx_second got=%0b/%h/%h exp=1/500/2", bus.upd_valid, bus.upd_pc, bus.upd_target); end
        n_vec++; if (bus.coalesce_cnt !== exp_cnt) begin n_err++; $display("FAIL b2b_hdx_cnt got=%0d exp=%0d", bus.coalesce_cnt, exp_cnt); end
        step();
    endtask

    task automatic test_kill();
        bus.btb_wr_stall = 1'b1;
        push_mp(32'h900, 32'h1);
        push_mp(32'h904, 32'h2);
        push_mp(32'h908, 32'h3);
        #1;
        n_vec++; if (bus.occupancy !== 3'd3) begin n_err++; $display("FAIL kill_fill got=%0d exp=3", bus.occupancy); end
        bus.btb_wr_stall = 1'b0;
        bus.kill = 1'b1;
        bus.mp_valid = 1'b1; bus.mp_pc = 32'hA00; bus.mp_target = 32'h5;
        #1;
        n_vec++; if (bus.mp_ready !== 1'b0 || bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL kill_block got=%0b/%0b exp=0/0", bus.mp_ready, bus.upd_valid); end
        step();
        bus.kill = 1'b0;
        bus.mp_valid = 1'b0;
        #1;
        n_vec++; if (bus.occupancy !== 3'd0 || bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL kill_empty got=%0d/%0b exp=0/0", bus.occupancy, bus.upd_valid); end
        n_vec++; if (bus.coalesce_cnt !== exp_cnt) begin n_err++; $display("FAIL kill_cnt got=%0d exp=%0d", bus.coalesce_cnt, exp_cnt); end
        push_mp(32'hB00, 32'hB1);
        #1;
        n_vec++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'hB00 || bus.upd_target !== 32'hB1) begin n_err++; $display("FAIL kill_after got=%0b/%h/%h exp=1/b00/b1", bus.upd_valid, bus.upd_pc, bus.upd_target); end
        step();
    endtask

    task automatic test_rst();
        bus.btb_wr_stall = 1'b1;
        push_mp(32'hC00, 32'h1);
        push_mp(32'hC04, 32'h2);
        push_mp(32'hC00, 32'h3);
        push_mp(32'hC08, 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.btb_wr_stall = 1'b0;
        #1;
        n_vec++; if (bus.occupancy !== 3'd0 || bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL rst_empty got=%0d/%0b exp=0/0", bus.occupancy, bus.upd_valid); end
        n_vec++; if (bus.coalesce_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", bus.coalesce_cnt); end
        n_vec++; if (bus.mp_ready !== 1'b1 || bus.cm_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%0b/%0b exp=1/1", bus.mp_ready, bus.cm_ready); end
        step();
        n_vec++; if (bus.upd_valid !== 1'b0) begin n_err++; $display("FAIL rst_lost got=%0b exp=0", bus.upd_valid); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_cnt = '0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_priority();
        test_coalesce();
        test_full();
        test_full_pop();
        test_back_to_back();
        test_kill();
        test_rst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
